pipe_stage_reg: RTL and testbench
=================================

// Module: pipe_stage_reg
// PURPOSE
//  Generic parametrised pipeline stage register for the CPU datapath (IF/ID, ID/EX, EX/MEM, MEM/WB).
//  - Carries a DATA_W payload and CTRL_W control bits.
//  - Adds valid/ready flow control, synchronous flush (bubble insertion) and a 2-entry skid buffer,
//    so ready_o does not depend combinationally on ready_i.
// PARAMETERS
//  DATA_W      32     payload width (ALU result, store data, rd address, ... concatenated)
//  CTRL_W      4      control-signal width (RegWrite, MemtoReg, MemRead, MemWrite, ...)
//  CTRL_BUBBLE 0      ctrl_o value presented when stage is empty/flushed (NOP control)
// PORTS
//  clk_i     in   1       clock, rising edge
//  rst_n_i   in   1       asynchronous active-low reset
//  start_i   in   1       stage enable; 0 freezes the stage
//  flush_i   in   1       synchronous flush, discards all held beats
//  valid_i   in   1       upstream beat valid
//  ready_o   out  1       stage can accept a beat
//  data_i    in   DATA_W  upstream payload
//  ctrl_i    in   CTRL_W  upstream control bits
//  valid_o   out  1       downstream beat valid
//  ready_i   in   1       downstream accepts
//  data_o    out  DATA_W  held payload
//  ctrl_o    out  CTRL_W  held control bits (CTRL_BUBBLE when valid_o=0)
//  occ_o     out  2       occupancy 0..2
// BEHAVIOUR
//  - accept = valid_i & ready_o; drain = valid_o & ready_i.
//  - Storage: out register (drives data_o/ctrl_o) plus skid register.
//  - State: EMPTY(occ 0), ONE(occ 1), FULL(occ 2).
//  - ready_o = start_i & (state!=FULL); valid_o = start_i & (state!=EMPTY).
//  - Transitions (start_i=1, flush_i=0):
//    EMPTY: accept -> ONE, out<=in.
//    ONE: accept&drain -> ONE, out<=in; accept&!drain -> FULL, skid<=in; drain only -> EMPTY; else hold.
//    FULL: drain -> ONE, out<=skid. No accept possible.
//  - Latency: beat accepted into EMPTY appears on valid_o/data_o next cycle.
//  - Ordering: strict FIFO; a beat is never duplicated or dropped except by flush.
//  - start_i=0: ready_o=0, valid_o=0, ctrl_o=CTRL_BUBBLE, all registers hold.
//    Beats resume unchanged when start_i returns to 1.
//  - flush_i=1 (highest priority, only when start_i=1):
//    next state EMPTY, data regs<=0, ctrl regs<=CTRL_BUBBLE.
//    A same-cycle accept or drain is void: the upstream beat is lost and no transfer is counted.
//  - Reset (rst_n_i=0, async): state EMPTY, data regs 0, ctrl regs CTRL_BUBBLE, valid_o=0,
//    occ_o=0, ready_o=start_i. Reset mid-transfer discards all beats.
//  - ctrl_o is forced to CTRL_BUBBLE whenever valid_o=0, so a bubble never asserts writes.
//  - No width arithmetic; occ_o saturates at 2 by construction.
// CONFIGURATION
//  PIPE_SKID_EN defined:
//    2-entry skid as above; ready_o depends only on state and start_i.
//  PIPE_SKID_EN undefined:
//    single entry, FULL state and skid register absent;
//    ready_o = start_i & (state==EMPTY | ready_i) (combinational through ready_i); occ_o max 1;
//    ONE with accept&drain -> ONE, out<=in.
//    Flush, reset and start_i rules are unchanged.
// TESTING
//  1. Reset: rst_n_i=0 with valid_i=1 -> valid_o=0, occ_o=0, ctrl_o=CTRL_BUBBLE.
//     Release, send data 0x11 -> valid_o=1 with data_o=0x11 one cycle later.
//  2. Back-pressure: ready_i=0, push 0xA1, 0xA2 -> occ_o=2, ready_o=0.
//     Raise ready_i -> outputs 0xA1 then 0xA2, occ_o 1 then 0.
//     Without PIPE_SKID_EN -> ready_o=0 after 0xA1 and 0xA2 is not accepted.
//  3. Throughput: ready_i=1, valid_i=1, 8 beats 0..7 -> one output per cycle, in order, occ_o=1 steady.
//  4. Flush: occ_o=2 and valid_i=1 with data 0x55, pulse flush_i -> next cycle occ_o=0, valid_o=0,
//     ctrl_o=CTRL_BUBBLE; 0x55 never appears.
//  5. Freeze: occ_o=1 holding 0x33, start_i=0 for 3 cycles with ready_i=1 -> valid_o=0, ready_o=0;
//     start_i=1 -> 0x33 delivered once.
//  6. Async reset mid-transfer: assert rst_n_i between clock edges while occ_o=2 -> outputs clear
//     immediately, no beat emitted after release.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
//   Parametrised CPU pipeline stage register (IF/ID, ID/EX, EX/MEM, MEM/WB)
//   with valid/ready flow control, synchronous flush and optional skid entry.
//
//   Build option: PIPE_SKID_EN
//     defined   - 2-entry stage (out + skid register); ready_o depends only
//                 on state and start_i.
//     undefined - 1-entry stage; ready_o = start_i & (empty | ready_i).
//
//   Ports
//     clk_i    clock, rising edge
//     rst_n_i  asynchronous active-low reset
//     start_i  stage enable; 0 freezes all state and hides the beats
//     flush_i  synchronous flush, discards all held beats
//     valid_i  upstream beat valid        ready_o  stage can accept
//     data_i   upstream payload           ctrl_i   upstream control bits
//     valid_o  downstream beat valid      ready_i  downstream accepts
//     data_o   held payload               ctrl_o   held control (bubble when !valid_o)
//     occ_o    occupancy 0..2
//
//   state   | meaning
//   --------+----------------------------------------------
//   S_EMPTY | no beat held, occ 0
//   S_ONE   | one beat in the out register, occ 1
//   S_FULL  | out and skid registers both hold beats, occ 2
module pipe_stage_reg #(
  parameter int                 DATA_W      = 32,
  parameter int                 CTRL_W      = 4,
  parameter logic [CTRL_W-1:0]  CTRL_BUBBLE = '0
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DATA_W-1:0] data_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [1:0]        occ_o
);

  // Encoding equals occupancy so occ_o is a direct view of the state.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t             state;
  logic [DATA_W-1:0]  out_data;
  logic [CTRL_W-1:0]  out_ctrl;
`ifdef PIPE_SKID_EN
  logic [DATA_W-1:0]  skid_data;
  logic [CTRL_W-1:0]  skid_ctrl;
`endif
  logic               accept;
  logic               drain;

`ifdef PIPE_SKID_EN
  assign ready_o = start_i & (state != S_FULL);
`else
  // Single entry: can take a new beat while the held one leaves this cycle.
  assign ready_o = start_i & ((state == S_EMPTY) | ready_i);
`endif
  assign valid_o = start_i & (state != S_EMPTY);
  assign accept  = valid_i & ready_o;
  assign drain   = valid_o & ready_i;

  assign data_o  = out_data;
  // A bubble must never carry write enables downstream.
  assign ctrl_o  = valid_o ? out_ctrl : CTRL_BUBBLE;
  assign occ_o   = state;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= S_EMPTY;
      out_data  <= '0;
      out_ctrl  <= CTRL_BUBBLE;
`ifdef PIPE_SKID_EN
      skid_data <= '0;
      skid_ctrl <= CTRL_BUBBLE;
`endif
    end else if (start_i) begin
      if (flush_i) begin
        // Flush wins over any same-cycle accept or drain.
        state     <= S_EMPTY;
        out_data  <= '0;
        out_ctrl  <= CTRL_BUBBLE;
`ifdef PIPE_SKID_EN
        skid_data <= '0;
        skid_ctrl <= CTRL_BUBBLE;
`endif
      end else begin
        case (state)
          S_EMPTY: begin
            if (accept) begin
              out_data <= data_i;
              out_ctrl <= ctrl_i;
              state    <= S_ONE;
            end
          end
          S_ONE: begin
            if (accept && drain) begin
              out_data <= data_i;
              out_ctrl <= ctrl_i;
`ifdef PIPE_SKID_EN
            end else if (accept) begin
              skid_data <= data_i;
              skid_ctrl <= ctrl_i;
              state     <= S_FULL;
`endif
            end else if (drain) begin
              state <= S_EMPTY;
            end
          end
`ifdef PIPE_SKID_EN
          S_FULL: begin
            if (drain) begin
              out_data <= skid_data;
              out_ctrl <= skid_ctrl;
              state    <= S_ONE;
            end
          end
`endif
          default: state <= S_EMPTY;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

  localparam int         DW  = 32;
  localparam int         CW  = 4;
  localparam logic [3:0] BUB = 4'h8;

  logic          clk_i = 1'b0;
  logic          rst_n_i;
  logic          start_i, flush_i, valid_i, ready_i;
  logic [DW-1:0] data_i;
  logic [CW-1:0] ctrl_i;
  logic          ready_o, valid_o;
  logic [DW-1:0] data_o;
  logic [CW-1:0] ctrl_o;
  logic [1:0]    occ_o;

  int checks = 0;
  int errors = 0;
  logic [CW+DW-1:0] sb[$];

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CTRL_BUBBLE(BUB)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i), .flush_i(flush_i),
    .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i), .ctrl_i(ctrl_i),
    .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o), .ctrl_o(ctrl_o),
    .occ_o(occ_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: a transfer happens at the next rising edge when valid_o & ready_i
  // and no flush is pending; compare it against the oldest expected beat.
  always @(negedge clk_i) begin
    if (rst_n_i && valid_o && ready_i && !flush_i) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat: got data 0x%0h ctrl 0x%0h expected none", data_o, ctrl_o);
      end else begin
        logic [CW+DW-1:0] exp;
        exp = sb.pop_front();
        if ({ctrl_o, data_o} !== exp) begin
          errors++;
          $display("FAIL beat: got 0x%0h expected 0x%0h", {ctrl_o, data_o}, exp);
        end
      end
    end
  end

  // One cycle: drive inputs, record the beat if expected to be accepted,
  // check handshake/occupancy mid-cycle, then move to just after the edge.
  task automatic drive(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                       input logic rdy, input logic st, input logic fl,
                       input logic er, input logic ev, input logic [1:0] eo,
                       input string tag);
    valid_i = v; data_i = d; ctrl_i = c; ready_i = rdy; start_i = st; flush_i = fl;
    if (st && fl) sb.delete();
    else if (st && v && er) sb.push_back({c, d});
    @(negedge clk_i);
    chk({tag, "_ready"}, 36'(ready_o), 36'(er));
    chk({tag, "_valid"}, 36'(valid_o), 36'(ev));
    chk({tag, "_occ"},   36'(occ_o),   36'(eo));
    @(posedge clk_i); #1;
  endtask

  task automatic idle(input logic er, input logic ev, input logic [1:0] eo, input string tag);
    drive(1'b0, '0, '0, 1'b1, 1'b1, 1'b0, er, ev, eo, tag);
  endtask

  initial begin
    // 1. reset with valid_i high
    rst_n_i = 1'b0; start_i = 1'b1; flush_i = 1'b0; valid_i = 1'b1;
    ready_i = 1'b1; data_i = 32'hDEAD; ctrl_i = 4'h3;
    #2;
    chk("rst_valid", 36'(valid_o), 36'(0));
    chk("rst_occ",   36'(occ_o),   36'(0));
    chk("rst_ctrl",  36'(ctrl_o),  36'(BUB));
    chk("rst_ready", 36'(ready_o), 36'(1));
    @(posedge clk_i);
    valid_i = 1'b0;
    @(negedge clk_i);
    rst_n_i = 1'b1;
    @(posedge clk_i); #1;

    drive(1'b1, 32'h11, 4'h1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, "t1_acc");
    chk("t1_data", 36'(data_o), 36'h11);
    idle(1'b1, 1'b1, 2'd1, "t1_out");
    idle(1'b1, 1'b0, 2'd0, "t1_empty");

    // 2. back-pressure
`ifdef PIPE_SKID_EN
    drive(1'b1, 32'hA1, 4'h2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, "t2_a1");
    drive(1'b1, 32'hA2, 4'h3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, "t2_a2");
    drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, "t2_full");
    idle(1'b0, 1'b1, 2'd2, "t2_drain1");
    idle(1'b1, 1'b1, 2'd1, "t2_drain2");
`else
    drive(1'b1, 32'hA1, 4'h2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, "t2_a1");
    drive(1'b1, 32'hA2, 4'h3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, "t2_a2_refused");
    idle(1'b1, 1'b1, 2'd1, "t2_drain1");
`endif
    idle(1'b1, 1'b0, 2'd0, "t2_empty");

    // 3. throughput
    for (int i = 0; i < 8; i++)
      drive(1'b1, 32'(i), 4'(i + 1), 1'b1, 1'b1, 1'b0, 1'b1, (i != 0), (i == 0) ? 2'd0 : 2'd1, "t3_stream");
    idle(1'b1, 1'b1, 2'd1, "t3_last");
    idle(1'b1, 1'b0, 2'd0, "t3_empty");

    // 4. flush with a beat offered in the same cycle
    drive(1'b1, 32'h44, 4'h4, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, "t4_fill1");
`ifdef PIPE_SKID_EN
    drive(1'b1, 32'h45, 4'h5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, "t4_fill2");
    drive(1'b1, 32'h55, 4'h6, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd2, "t4_flush");
`else
    drive(1'b1, 32'h55, 4'h6, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd1, "t4_flush");
`endif
    chk("t4_occ",   36'(occ_o),   36'(0));
    chk("t4_valid", 36'(valid_o), 36'(0));
    chk("t4_ctrl",  36'(ctrl_o),  36'(BUB));
    chk("t4_data",  36'(data_o),  36'(0));
    idle(1'b1, 1'b0, 2'd0, "t4_after");

    // 5. freeze
    drive(1'b1, 32'h33, 4'h7, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, "t5_fill");
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, "t5_frozen");
      chk("t5_ctrl", 36'(ctrl_o), 36'(BUB));
    end
    idle(1'b1, 1'b1, 2'd1, "t5_resume");
    idle(1'b1, 1'b0, 2'd0, "t5_empty");

    // 6. async reset mid-transfer
    drive(1'b1, 32'h66, 4'h9, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, "t6_fill1");
`ifdef PIPE_SKID_EN
    drive(1'b1, 32'h67, 4'hA, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, "t6_fill2");
    chk("t6_occ_pre", 36'(occ_o), 36'(2));
`else
    chk("t6_occ_pre", 36'(occ_o), 36'(1));
`endif
    #2;
    rst_n_i = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b1;
    sb.delete();
    #1;
    chk("t6_valid", 36'(valid_o), 36'(0));
    chk("t6_occ",   36'(occ_o),   36'(0));
    chk("t6_ctrl",  36'(ctrl_o),  36'(BUB));
    chk("t6_data",  36'(data_o),  36'(0));
    #3;
    rst_n_i = 1'b1;
    @(posedge clk_i); #1;
    idle(1'b1, 1'b0, 2'd0, "t6_after1");
    idle(1'b1, 1'b0, 2'd0, "t6_after2");

    chk("sb_empty", 36'(sb.size()), 36'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
